// File: rtl/rggen_wishbone_timeout_counter.sv
// Purpose : clear/enable saturating cycle counter; o_hit is high while the count equals LIMIT.
// Latency : registered count, o_hit is a compare on the registered value (no input-to-output path).
// Backpressure: none; i_clear wins over i_enable, and the count holds at LIMIT instead of wrapping.
// Ports   : i_clk/i_rst (sync active-high), i_clear, i_enable, o_hit.
module rggen_wishbone_timeout_counter #(
    parameter int LIMIT = 1
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);
    localparam int              CW      = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0]   LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != LIMIT_V)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_hit = (count_q == LIMIT_V);

endmodule

// File: rtl/rggen_wishbone_request_slice.sv
// Purpose : registered pipelined-Wishbone slice in front of the register adapter, one transfer in flight.
// Latency : accept at edge N -> o_m_stb in N+1 -> zero-wait ack in N+2 -> o_s_ack/err/rty in N+3.
// Backpressure: o_s_stall is high whenever a transfer is in flight; requests seen while stalled are dropped.
// Ports   : i_clk/i_rst (sync active-high); i_s_* / o_s_* master side; o_m_* / i_m_* downstream side.
//           Optional watchdog (TIMEOUT_CYCLES>0) answers err with TIMEOUT_READ_DATA when downstream is silent.
module rggen_wishbone_request_slice #(
    parameter int                   ADDRESS_WIDTH     = 8,
    parameter int                   BUS_WIDTH         = 32,
    parameter int                   TIMEOUT_CYCLES    = 0,
    parameter logic [BUS_WIDTH-1:0] TIMEOUT_READ_DATA = '0
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_s_cyc,
    input  logic                     i_s_stb,
    output logic                     o_s_stall,
    input  logic [ADDRESS_WIDTH-1:0] i_s_adr,
    input  logic                     i_s_we,
    input  logic [BUS_WIDTH-1:0]     i_s_dat,
    input  logic [BUS_WIDTH/8-1:0]   i_s_sel,
    output logic                     o_s_ack,
    output logic                     o_s_err,
    output logic                     o_s_rty,
    output logic [BUS_WIDTH-1:0]     o_s_dat,
    output logic                     o_m_cyc,
    output logic                     o_m_stb,
    input  logic                     i_m_stall,
    output logic [ADDRESS_WIDTH-1:0] o_m_adr,
    output logic                     o_m_we,
    output logic [BUS_WIDTH-1:0]     o_m_dat,
    output logic [BUS_WIDTH/8-1:0]   o_m_sel,
    input  logic                     i_m_ack,
    input  logic                     i_m_err,
    input  logic                     i_m_rty,
    input  logic [BUS_WIDTH-1:0]     i_m_dat
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    logic [1:0]               state_q,  state_d;
    logic [ADDRESS_WIDTH-1:0] adr_q,    adr_d;
    logic                     we_q,     we_d;
    logic [BUS_WIDTH-1:0]     wdat_q,   wdat_d;
    logic [BUS_WIDTH/8-1:0]   sel_q,    sel_d;
    logic                     ack_q,    ack_d;
    logic                     err_q,    err_d;
    logic                     rty_q,    rty_d;
    logic [BUS_WIDTH-1:0]     rdat_q,   rdat_d;

    logic in_xfer;
    logic m_response;
    logic timeout_hit;

    assign in_xfer    = (state_q == ST_REQUEST) || (state_q == ST_WAIT);
    assign m_response = i_m_ack || i_m_err || i_m_rty;

    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
        rggen_wishbone_timeout_counter #(
            .LIMIT (TIMEOUT_CYCLES)
        ) u_timeout_counter (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_clear  (state_q == ST_IDLE),
            .i_enable (in_xfer),
            .o_hit    (timeout_hit)
        );
    end else begin : g_no_watchdog
        assign timeout_hit = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        // Response flags are single-cycle pulses: only set on the edge entering RESPOND.
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_s_cyc && i_s_stb) begin
                    state_d = ST_REQUEST;
                    adr_d   = i_s_adr;
                    we_d    = i_s_we;
                    wdat_d  = i_s_dat;
                    sel_d   = i_s_sel;
                end
            end
            ST_REQUEST, ST_WAIT: begin
                // Master abandoning the cycle beats any response or timeout in the same cycle.
                if (!i_s_cyc) begin
                    state_d = ST_IDLE;
                end else if (m_response) begin
                    state_d = ST_RESPOND;
                    err_d   = i_m_err;
                    rty_d   = !i_m_err && i_m_rty;
                    ack_d   = !i_m_err && !i_m_rty;
                    rdat_d  = i_m_dat;
                end else if (timeout_hit) begin
                    state_d = ST_RESPOND;
                    err_d   = 1'b1;
                    rdat_d  = TIMEOUT_READ_DATA;
                end else if ((state_q == ST_REQUEST) && !i_m_stall) begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            rdat_q  <= rdat_d;
        end
    end

    assign o_s_stall = (state_q != ST_IDLE);
    assign o_s_ack   = ack_q;
    assign o_s_err   = err_q;
    assign o_s_rty   = rty_q;
    assign o_s_dat   = rdat_q;

    assign o_m_cyc   = in_xfer;
    assign o_m_stb   = (state_q == ST_REQUEST);
    assign o_m_adr   = adr_q;
    assign o_m_we    = we_q;
    assign o_m_dat   = wdat_q;
    assign o_m_sel   = sel_q;

endmodule

// File: doc/rggen_wishbone_request_slice.md
Name: rggen_wishbone_request_slice

Overview:
- Registered pipelined-Wishbone slice placed directly upstream of the Wishbone register adapter: master (CPU/interconnect) -> slice -> adapter.
- Breaks the combinational path from master request signals into the adapter's decode logic.
- Enforces a single outstanding transfer.
- Adds a watchdog that answers with err when the downstream side never responds, and drops the downstream cycle cleanly when the master abandons it.

Parameters:
ADDRESS_WIDTH, 8, width of s/m address buses
BUS_WIDTH, 32, data width; must be a multiple of 8
TIMEOUT_CYCLES, 0, watchdog limit in cycles counted from first m_stb; 0 = watchdog disabled
TIMEOUT_READ_DATA, {BUS_WIDTH{1'b0}}, value returned on o_s_dat for a timed-out transfer

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_s_cyc  input  1  master cycle
i_s_stb  input  1  master strobe
o_s_stall  output  1  slice busy; request not accepted
i_s_adr  input  ADDRESS_WIDTH  master address
i_s_we  input  1  master write enable
i_s_dat  input  BUS_WIDTH  master write data
i_s_sel  input  BUS_WIDTH/8  master byte select
o_s_ack  output  1  response: ok
o_s_err  output  1  response: error or timeout
o_s_rty  output  1  response: retry
o_s_dat  output  BUS_WIDTH  read data to master
o_m_cyc  output  1  downstream cycle
o_m_stb  output  1  downstream strobe
i_m_stall  input  1  downstream stall
o_m_adr  output  ADDRESS_WIDTH  registered address
o_m_we  output  1  registered write enable
o_m_dat  output  BUS_WIDTH  registered write data
o_m_sel  output  BUS_WIDTH/8  registered byte select
i_m_ack  input  1  downstream ack
i_m_err  input  1  downstream err
i_m_rty  input  1  downstream rty
i_m_dat  input  BUS_WIDTH  downstream read data

Behaviour:
- Reset: when i_rst=1 at a clock edge:
  - state=IDLE; all outputs 0 except o_s_stall, which follows state (0 in IDLE).
  - Request registers, response registers and timeout counter cleared.
  - A reset mid-transfer drops o_m_cyc on the next cycle and produces no response.
- States: IDLE, REQUEST, WAIT, RESPOND. o_s_stall = (state != IDLE), combinational from state only.
- IDLE:
  - Accept when i_s_cyc & i_s_stb.
  - Capture adr/we/dat/sel into o_m_* registers; go to REQUEST.
- REQUEST:
  - o_m_cyc=1, o_m_stb=1.
  - If !i_m_stall, go to WAIT (o_m_stb drops the next cycle).
- WAIT: o_m_cyc=1, o_m_stb=0.
- Response capture:
  - Applies in REQUEST or WAIT on i_m_ack|i_m_err|i_m_rty.
  - Latch the flags and o_s_dat<=i_m_dat; go to RESPOND; o_m_cyc deasserts the next cycle.
  - If more than one flag is set, priority is err > rty > ack; exactly one of o_s_ack/err/rty is ever driven.
- RESPOND:
  - Exactly one of o_s_ack/o_s_err/o_s_rty is high for one cycle, registered.
  - o_m_cyc=0. Next state is IDLE.
  - The earliest next accept is the cycle after RESPOND.
- Latency, zero-wait downstream: accept at edge N; o_m_stb high in cycle N+1; adapter ack in cycle N+2; o_s_ack in cycle N+3.
- o_s_dat holds its last value until the next captured response.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears in IDLE and increments each cycle in REQUEST/WAIT.
  - When the counter reaches TIMEOUT_CYCLES with no response that cycle: go to RESPOND with o_s_err=1, o_s_dat=TIMEOUT_READ_DATA, o_m_cyc/o_m_stb dropped.
  - A response arriving in the same cycle as the timeout wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Abort:
  - If i_s_cyc=0 in REQUEST or WAIT: go to IDLE, drop o_m_cyc/o_m_stb the next cycle, generate no response.
  - A downstream response that arrives in the abort cycle is discarded.
  - Abort has priority over response and timeout.
- RESPOND always completes regardless of i_s_cyc.
- Priority order: reset > abort > response > timeout > stall progress.
- i_s_stb while stalled is ignored; no queueing.

Decomposition:
- No shared package; parameters are local.
- State encoding is a local 2-bit localparam set: IDLE=0, REQUEST=1, WAIT=2, RESPOND=3.
- One natural sub-module, rggen_wishbone_timeout_counter: clear/enable/saturating counter with a hit output. It is generated only when TIMEOUT_CYCLES>0; otherwise hit is tied to 0.

Test Plan:
- Single write, zero-wait adapter:
  - Stimulus: adr=0x10, dat=0xDEADBEEF, sel=0xF.
  - Required: o_m_stb one cycle with those values; o_s_ack exactly 3 cycles after accept; o_s_stall high for 3 cycles.
- Read, downstream i_m_stall=1 for 2 cycles then ack with i_m_dat=0x12345678:
  - Required: o_m_stb held 3 cycles; o_s_ack with o_s_dat=0x12345678; no other response flag.
- Error response, i_m_err=1:
  - Required: o_s_err single pulse, o_s_ack=0.
  - Back-to-back requests: the second is accepted only the cycle after RESPOND; both complete in order.
- Timeout, TIMEOUT_CYCLES=4, downstream silent:
  - Required: o_s_err 5 cycles after o_m_stb first rises; o_s_dat=TIMEOUT_READ_DATA; o_m_cyc low afterwards.
  - Variant: ack in the same cycle as the timeout -> o_s_ack, not err.
- Abort: i_s_cyc dropped in WAIT.
  - Required: o_m_cyc low the next cycle; no o_s_ack/err/rty; a later i_m_ack is ignored; a new request is accepted.
- Reset mid-transfer: i_rst pulsed in WAIT.
  - Required: all outputs 0 the next cycle, o_s_stall=0, no response pulse.
